// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key map and default timing constants for the keypad scanner
package keypad_pkg;
  localparam int SCAN_DIV_DEF = 100000;
  localparam int DEBOUNCE_CNT_DEF = 4;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  // Indexed by {column, row}: column-major, four rows per column
  localparam logic [0:15][3:0] KEY_MAP = {
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop 4-bit synchronizer, resets to all ones (keys released)
// clk/reset: system clock, async active-low reset; d: async input; q: synchronized output
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and one-shot key valid
// clk/reset: system clock, async active-low reset
// keyPad_row: raw active-low rows; keyPad_column: one-cold column drive
// digit: hex code of last accepted key; valid: one-cycle pulse with each new digit
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPad_row,
  output logic [3:0] keyPad_column,
  output logic [3:0] digit,
  output logic       valid
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_CNT);
  logic [3:0] row_s, low;
  logic [DW-1:0] dwell;
  logic [1:0] col, row_idx, low_idx;
  logic [MW-1:0] match_cnt, rel_cnt;
  logic sample, one_low, all_high, match;
  state_t state;
  keypad_sync u_sync (.clk(clk), .reset(reset), .d(keyPad_row), .q(row_s));
  assign low = ~row_s;
  assign sample = dwell == DW'(SCAN_DIV - 1);
  assign one_low = (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  assign low_idx = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign all_high = row_s == 4'hF;
  assign match = row_s == ~(4'b1 << row_idx);
  assign keyPad_column = ~(4'b1 << col);
  // Counts only ever hold up to DEBOUNCE_CNT-1: reaching DEBOUNCE_CNT is the transition itself
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SCAN;
      dwell <= '0;
      col <= '0;
      row_idx <= '0;
      match_cnt <= '0;
      rel_cnt <= '0;
      digit <= 4'h0;
      valid <= 1'b0;
    end else begin
      dwell <= sample ? '0 : dwell + 1'b1;
      valid <= 1'b0;
      if (sample)
        case (state)
          SCAN:
            if (one_low) begin
              row_idx <= low_idx;
              match_cnt <= MW'(1);
              state <= DEBOUNCE;
            end else col <= col + 2'd1;
          DEBOUNCE:
            if (!match) begin
              state <= SCAN;
              col <= col + 2'd1;
            end else if (match_cnt == MW'(DEBOUNCE_CNT - 1)) begin
              valid <= 1'b1;
              digit <= KEY_MAP[{col, row_idx}];
              state <= HELD;
            end else match_cnt <= match_cnt + 1'b1;
          HELD:
            if (all_high) begin
              rel_cnt <= MW'(1);
              state <= RELEASE;
            end
          RELEASE:
            if (!all_high) state <= HELD;
            else if (rel_cnt == MW'(DEBOUNCE_CNT - 1)) begin
              state <= SCAN;
              col <= col + 2'd1;
            end else rel_cnt <= rel_cnt + 1'b1;
        endcase
    end
endmodule
